input_adapter_high_perf: RTL and testbench
==========================================

Name: input_adapter_high_perf

Overview:
- Ingress-side counterpart of the output adapter in the high-performance Dilithium top.
- Accepts the external 64-bit valid/ready input stream, frames it per operation (mode, sec_lvl) and forwards it to combined_top through a registered 2-entry skid stage.
- Counts words, tags the final word, and blocks any surplus input.
- Reports completion and framing errors.

Parameters:
- CNT_W, 24: width of the word counters.
- MAX_MLEN_BYTES, 1048576: largest legal message length in bytes. A larger value is an error.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; samples mode and sec_lvl and begins a frame
- mode  in  2  0 keygen, 1 verify, 2 sign, 3 illegal
- sec_lvl  in  3  2, 3 or 5; any other value is illegal
- valid_i  in  1  external word valid
- ready_i  out  1  external word accepted; driven from a register
- data_i  in  64  external word
- core_valid_o  out  1  word valid toward the core
- core_ready_o  in  1  core accepts the word
- core_data_o  out  64  word toward the core
- core_last_o  out  1  qualifies the final word of the frame on core_data_o
- in_done  out  1  frame fully delivered to the core; held high until the next start
- in_error  out  1  framing error; held high until the next start or reset

Behaviour:
- Reset values: ready_i=0, core_valid_o=0, core_data_o=0, core_last_o=0, in_done=0, in_error=0. State is IDLE, both skid entries are empty and all counters are 0.
- Frame layout (word counts):
  - Keygen: 4 seed words.
  - Sign: 1 header word, then M message words, then SK words. SK = 316 / 500 / 608 for sec_lvl 2 / 3 / 5.
  - Verify: 1 header word, then M message words, then PK words, then SIG words. PK = 164 / 244 / 324 and SIG = 303 / 412 / 575 for sec_lvl 2 / 3 / 5.
  - Header word: bits[31:0] carry mlen in bytes; bits[63:32] are ignored. M = ceil(mlen/8).
  - Every word, including the header, is forwarded unmodified.
- State machine: IDLE, HEADER, STREAM, DONE, ERR.
  - IDLE -> start with an illegal mode or sec_lvl -> ERR. Otherwise keygen goes to STREAM with remaining=4; sign and verify go to HEADER.
  - HEADER: on header acceptance, if mlen > MAX_MLEN_BYTES go to ERR. Otherwise load remaining = M + fixed words and go to STREAM.
  - HEADER: if the computed remaining is 0, go to STREAM; remaining=0 cannot occur because the fixed words are always > 0.
  - STREAM: each accepted word (valid_i & ready_i) decrements remaining. The word accepted at remaining=1 is tagged last. After that acceptance ready_i drops on the next cycle.
  - STREAM -> DONE when the last-tagged word handshakes on the core side (core_valid_o & core_ready_o & core_last_o).
  - DONE and ERR: ready_i=0 and the skid stage is flushed. Stay until start.
- Skid stage:
  - ready_i = (state is HEADER or STREAM) & (skid has fewer than 2 entries) & (word budget not exhausted).
  - Latency from input acceptance to core_valid_o is exactly 1 cycle when core_ready_o=1.
  - Full throughput: 1 word per cycle under continuous valid_i and core_ready_o.
  - No word is lost or duplicated under arbitrary core_ready_o backpressure. Order is preserved.
  - core_data_o and core_last_o hold stable while core_valid_o=1 and core_ready_o=0.
- Simultaneous events:
  - start in any state aborts the current frame: the skid is flushed, in_done and in_error clear, and the new frame begins. Frames are not queued.
  - start in the same cycle as an input handshake: the old word is dropped and the new frame wins.
  - mode and sec_lvl are registered at start. Later changes are ignored.
- Reset mid-operation: immediate return to the reset values. Any partially forwarded frame is abandoned.
- Counters saturate at 0 and never wrap. The remaining counter is CNT_W bits wide, and the maximum total for verify lvl5 is 1 + 131072 + 899, which fits.

Test Plan:
- Keygen at sec_lvl=2 with 4 words and continuous valid and ready -> 4 words appear on core_data_o 1 cycle delayed, core_last_o on word 4, in_done=1 the cycle after the last core handshake, ready_i=0 afterwards, and a 5th valid_i word is never accepted.
- Sign at sec_lvl=3 with header mlen=13 -> 1 + 2 + 500 = 503 words forwarded, core_last_o on word 503, in_done=1.
- Verify at sec_lvl=5 with mlen=0 -> 1 + 324 + 575 = 900 words forwarded and in_done=1.
- Sign at sec_lvl=2 with mlen=100 and random 50% core_ready_o stalls -> 1 + 13 + 316 = 330 words in order with no loss or duplication, and core_data_o stable during stalls.
- Error cases -> each raises in_error=1 with ready_i=0:
  - start with sec_lvl=4.
  - start with mode=3.
  - Verify with header mlen = MAX_MLEN_BYTES + 1; in_error=1 the cycle after the header is accepted.
  - A subsequent legal start clears in_error.
- Abort and reset:
  - start pulse after 50 of 330 sign words -> the new frame counts from 0 and no stale skid word appears.
  - rst asserted mid-frame -> all outputs at reset values immediately.

Source files
------------

// File: rtl/input_adapter_high_perf_if.sv
// Ingress stream bundle: external 64-bit valid/ready input on one side and the
// framed word stream toward combined_top on the other.
interface input_adapter_high_perf_if;
  logic        valid_i;
  logic        ready_i;
  logic [63:0] data_i;
  logic        core_valid_o;
  logic        core_ready_o;
  logic [63:0] core_data_o;
  logic        core_last_o;

  // Adapter side: consumes the external stream, produces the core stream.
  modport slave (
    input  valid_i,
    input  data_i,
    input  core_ready_o,
    output ready_i,
    output core_valid_o,
    output core_data_o,
    output core_last_o
  );

  // Environment side: drives the external stream and the core back-pressure.
  modport master (
    output valid_i,
    output data_i,
    output core_ready_o,
    input  ready_i,
    input  core_valid_o,
    input  core_data_o,
    input  core_last_o
  );
endinterface

// File: rtl/input_adapter_high_perf.sv
// Ingress adapter for the high-performance Dilithium top. Frames the external
// 64-bit stream per operation, tags the final word and forwards everything to
// the core through a registered two-entry skid stage.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | no frame active, input blocked
// S_HEADER | waiting for the header word carrying mlen (sign / verify)
// S_STREAM | forwarding words, remaining counts words still to accept
// S_DONE   | last word delivered to the core, in_done held
// S_ERR    | illegal operation or oversized mlen, in_error held
module input_adapter_high_perf #(
  parameter int CNT_W          = 24,
  parameter int MAX_MLEN_BYTES = 1048576
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [1:0]                  mode,
  input  logic [2:0]                  sec_lvl,
  input_adapter_high_perf_if.slave    bus,
  output logic                        in_done,
  output logic                        in_error
);

  localparam logic [1:0] MODE_KEYGEN = 2'd0;
  localparam logic [1:0] MODE_VERIFY = 2'd1;
  localparam logic [1:0] MODE_SIGN   = 2'd2;
  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_STREAM,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state;
  logic [1:0]       mode_q;
  logic [2:0]       lvl_q;
  logic [CNT_W-1:0] remaining;

  // Skid entry 0 is the core-facing output register itself; entry 1 is the
  // overflow slot that absorbs the word in flight when the core stalls.
  logic [1:0]       skid_cnt;
  logic [63:0]      skid_data1;
  logic             skid_last1;

  logic             hs_in;
  logic             hs_core;
  logic             push_last;
  logic             mlen_bad;
  logic             start_legal;
  logic [31:0]      mlen;
  logic [32:0]      m_words;
  logic [CNT_W-1:0] hdr_total;
  logic [CNT_W-1:0] rem_dec;
  logic [1:0]       cnt_n;
  logic [63:0]      head_data_n;
  logic             head_last_n;
  logic [63:0]      tail_data_n;
  logic             tail_last_n;

  // Key material words that follow the message (SK for sign, PK+SIG for verify).
  function automatic logic [CNT_W-1:0] fixed_words(input logic [1:0] md,
                                                   input logic [2:0] lvl);
    logic [CNT_W-1:0] w;
    w = '0;
    if (md == MODE_SIGN) begin
      case (lvl)
        3'd2:    w = CNT_W'(316);
        3'd3:    w = CNT_W'(500);
        3'd5:    w = CNT_W'(608);
        default: w = '0;
      endcase
    end else if (md == MODE_VERIFY) begin
      case (lvl)
        3'd2:    w = CNT_W'(164 + 303);
        3'd3:    w = CNT_W'(244 + 412);
        3'd5:    w = CNT_W'(324 + 575);
        default: w = '0;
      endcase
    end
    return w;
  endfunction

  // Handshake decode, header arithmetic and remaining-count update.
  always_comb begin
    hs_in       = bus.valid_i & bus.ready_i;
    hs_core     = bus.core_valid_o & bus.core_ready_o;
    mlen        = bus.data_i[31:0];
    m_words     = ({1'b0, mlen} + 33'd7) >> 3;
    hdr_total   = CNT_W'(m_words) + fixed_words(mode_q, lvl_q);
    mlen_bad    = (mlen > 32'(MAX_MLEN_BYTES));
    push_last   = (state == S_STREAM) && (remaining == CNT_W'(1));
    rem_dec     = (hs_in && (remaining != '0)) ? remaining - CNT_W'(1) : remaining;
    start_legal = (mode != MODE_ILLEGAL) &&
                  ((sec_lvl == 3'd2) || (sec_lvl == 3'd3) || (sec_lvl == 3'd5));
  end

  // Next contents of the skid stage for every push/pop combination.
  always_comb begin
    cnt_n       = skid_cnt;
    head_data_n = bus.core_data_o;
    head_last_n = bus.core_last_o;
    tail_data_n = skid_data1;
    tail_last_n = skid_last1;
    case ({hs_in, hs_core})
      2'b11: begin
        if (skid_cnt == 2'd2) begin
          head_data_n = skid_data1;
          head_last_n = skid_last1;
          tail_data_n = bus.data_i;
          tail_last_n = push_last;
        end else begin
          head_data_n = bus.data_i;
          head_last_n = push_last;
        end
      end
      2'b10: begin
        if (skid_cnt == 2'd0) begin
          head_data_n = bus.data_i;
          head_last_n = push_last;
        end else begin
          tail_data_n = bus.data_i;
          tail_last_n = push_last;
        end
        cnt_n = skid_cnt + 2'd1;
      end
      2'b01: begin
        head_data_n = skid_data1;
        head_last_n = skid_last1;
        cnt_n       = skid_cnt - 2'd1;
      end
      default: ;
    endcase
  end

  // Frame FSM, skid registers and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      mode_q           <= '0;
      lvl_q            <= '0;
      remaining        <= '0;
      skid_cnt         <= '0;
      skid_data1       <= '0;
      skid_last1       <= 1'b0;
      bus.ready_i      <= 1'b0;
      bus.core_valid_o <= 1'b0;
      bus.core_data_o  <= '0;
      bus.core_last_o  <= 1'b0;
      in_done          <= 1'b0;
      in_error         <= 1'b0;
    end else if (start) begin
      // A new start always wins: anything in flight is dropped.
      mode_q           <= mode;
      lvl_q            <= sec_lvl;
      skid_cnt         <= '0;
      bus.core_valid_o <= 1'b0;
      bus.core_last_o  <= 1'b0;
      in_done          <= 1'b0;
      if (!start_legal) begin
        state       <= S_ERR;
        remaining   <= '0;
        bus.ready_i <= 1'b0;
        in_error    <= 1'b1;
      end else begin
        in_error    <= 1'b0;
        bus.ready_i <= 1'b1;
        if (mode == MODE_KEYGEN) begin
          state     <= S_STREAM;
          remaining <= CNT_W'(4);
        end else begin
          state     <= S_HEADER;
          remaining <= '0;
        end
      end
    end else begin
      case (state)
        S_HEADER, S_STREAM: begin
          skid_cnt         <= cnt_n;
          skid_data1       <= tail_data_n;
          skid_last1       <= tail_last_n;
          bus.core_valid_o <= (cnt_n != 2'd0);
          bus.core_data_o  <= head_data_n;
          bus.core_last_o  <= head_last_n;
          bus.ready_i      <= (cnt_n != 2'd2);
          if (state == S_HEADER) begin
            if (hs_in) begin
              if (mlen_bad) begin
                state            <= S_ERR;
                in_error         <= 1'b1;
                skid_cnt         <= '0;
                bus.core_valid_o <= 1'b0;
                bus.core_last_o  <= 1'b0;
                bus.ready_i      <= 1'b0;
              end else begin
                state     <= S_STREAM;
                remaining <= hdr_total;
              end
            end
          end else begin
            remaining <= rem_dec;
            // Word budget spent: block surplus input from the next cycle on.
            if (rem_dec == '0) begin
              bus.ready_i <= 1'b0;
            end
            if (hs_core && bus.core_last_o) begin
              state            <= S_DONE;
              in_done          <= 1'b1;
              skid_cnt         <= '0;
              bus.core_valid_o <= 1'b0;
              bus.core_last_o  <= 1'b0;
              bus.ready_i      <= 1'b0;
            end
          end
        end
        default: begin
          skid_cnt         <= '0;
          bus.core_valid_o <= 1'b0;
          bus.core_last_o  <= 1'b0;
          bus.ready_i      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_adapter_high_perf.sv
// Directed bench for input_adapter_high_perf: whole frames for each operation,
// back-pressure, error starts, abort by start and asynchronous reset.
module tb_input_adapter_high_perf;

  localparam int MAX_MLEN = 1048576;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic [2:0] sec_lvl;
  logic       in_done;
  logic       in_error;

  int n_checks;
  int n_errors;
  int frame_id;

  input_adapter_high_perf_if bus ();

  input_adapter_high_perf #(
    .CNT_W          (24),
    .MAX_MLEN_BYTES (MAX_MLEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .sec_lvl  (sec_lvl),
    .bus      (bus),
    .in_done  (in_done),
    .in_error (in_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ready"},  bus.ready_i,      1'b0);
    check_val({tag, "_cvalid"}, bus.core_valid_o, 1'b0);
    check_val({tag, "_cdata"},  bus.core_data_o,  64'h0);
    check_val({tag, "_clast"},  bus.core_last_o,  1'b0);
    check_val({tag, "_done"},   in_done,          1'b0);
    check_val({tag, "_error"},  in_error,         1'b0);
  endtask

  // Starts a frame, streams it with optional random core stalls and checks
  // order, last tagging, latency, throughput, completion and surplus blocking.
  // abort_at > 0 leaves the frame after that many accepted words.
  task automatic run_frame(input string tag, input logic [1:0] md, input logic [2:0] lvl,
                           input logic [31:0] mlen, input int exp_total, input bit stall,
                           input int abort_at);
    logic [63:0] words[$];
    int          acc_cyc[$];
    int          idx, n_out, cyc, budget, total;
    int          last_cyc, done_cyc, first_acc, last_acc;
    bit          prev_stall;
    logic [63:0] prev_data;
    logic        prev_last;

    frame_id++;
    total = exp_total + 3;
    for (int i = 0; i < total; i++) begin
      if (i == 0 && md != 2'd0) words.push_back({16'hC0DE, frame_id[15:0], mlen});
      else                      words.push_back({16'hDA7A, frame_id[15:0], 32'(i)});
    end

    // start pulse; the core side is held off so nothing is consumed meanwhile
    @(negedge clk);
    start = 1'b1;
    mode = md;
    sec_lvl = lvl;
    bus.core_ready_o = 1'b0;
    @(negedge clk);
    start = 1'b0;
    mode = 2'd3;
    sec_lvl = 3'd7;
    check_val({tag, "_flush"},     bus.core_valid_o, 1'b0);
    check_val({tag, "_err_clr"},   in_error,         1'b0);
    check_val({tag, "_done_clr"},  in_done,          1'b0);

    idx = 0; n_out = 0; cyc = 0;
    last_cyc = -1; first_acc = -1; last_acc = -1;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    budget = exp_total * 4 + 50;

    while (!in_done && cyc < budget && !(abort_at > 0 && idx >= abort_at)) begin
      if (prev_stall) begin
        check_val({tag, "_hold_data"}, bus.core_data_o, prev_data);
        check_val({tag, "_hold_last"}, bus.core_last_o, prev_last);
      end
      bus.core_ready_o = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.core_valid_o && bus.core_ready_o) begin
        check_val({tag, "_data"}, bus.core_data_o, words[n_out]);
        check_val({tag, "_last"}, bus.core_last_o, (n_out == exp_total - 1));
        if (!stall) check_val({tag, "_lat"}, 64'(cyc - acc_cyc[n_out]), 64'd1);
        if (bus.core_last_o) last_cyc = cyc;
        n_out++;
      end
      prev_stall = bus.core_valid_o && !bus.core_ready_o;
      prev_data  = bus.core_data_o;
      prev_last  = bus.core_last_o;

      if (idx < total) begin
        bus.valid_i = 1'b1;
        bus.data_i  = words[idx];
      end else begin
        bus.valid_i = 1'b0;
      end
      if (bus.valid_i && bus.ready_i) begin
        acc_cyc.push_back(cyc);
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    done_cyc = cyc;

    if (abort_at == 0) begin
      check_val({tag, "_done"},     in_done,          1'b1);
      check_val({tag, "_words"},    64'(n_out),       64'(exp_total));
      check_val({tag, "_accepted"}, 64'(idx),         64'(exp_total));
      check_val({tag, "_done_lat"}, 64'(done_cyc - last_cyc), 64'd1);
      check_val({tag, "_rdy_off"},  bus.ready_i,      1'b0);
      check_val({tag, "_cv_off"},   bus.core_valid_o, 1'b0);
      if (!stall) check_val({tag, "_tput"}, 64'(last_acc - first_acc), 64'(exp_total - 1));
      // surplus words stay offered but must never be taken
      for (int k = 0; k < 4; k++) begin
        bus.valid_i = 1'b1;
        bus.data_i  = words[idx];
        if (bus.valid_i && bus.ready_i) idx++;
        @(negedge clk);
      end
      check_val({tag, "_surplus"},  64'(idx), 64'(exp_total));
      check_val({tag, "_done_hold"}, in_done, 1'b1);
    end else begin
      check_val({tag, "_abort_cnt"}, 64'(idx), 64'(abort_at));
    end
  endtask

  task automatic err_start(input string tag, input logic [1:0] md, input logic [2:0] lvl);
    @(negedge clk);
    start = 1'b1;
    mode = md;
    sec_lvl = lvl;
    @(negedge clk);
    start = 1'b0;
    check_val({tag, "_error"}, in_error,    1'b1);
    check_val({tag, "_ready"}, bus.ready_i, 1'b0);
    check_val({tag, "_done"},  in_done,     1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    frame_id = 0;
    rst = 1'b1;
    start = 1'b0;
    mode = 2'd0;
    sec_lvl = 3'd2;
    bus.valid_i = 1'b0;
    bus.data_i = '0;
    bus.core_ready_o = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_rel");

    run_frame("kg2",   2'd0, 3'd2, 32'd0,   4,   1'b0, 0);
    run_frame("sg3",   2'd2, 3'd3, 32'd13,  503, 1'b0, 0);
    run_frame("vf5",   2'd1, 3'd5, 32'd0,   900, 1'b0, 0);
    run_frame("sg2st", 2'd2, 3'd2, 32'd100, 330, 1'b1, 0);

    bus.valid_i = 1'b0;
    err_start("e_lvl4", 2'd0, 3'd4);
    run_frame("kg_clr", 2'd0, 3'd3, 32'd0, 4, 1'b0, 0);
    bus.valid_i = 1'b0;
    err_start("e_mode3", 2'd3, 3'd2);

    // oversized header on a verify frame
    @(negedge clk);
    start = 1'b1;
    mode = 2'd1;
    sec_lvl = 3'd5;
    @(negedge clk);
    start = 1'b0;
    check_val("e_mlen_clr", in_error, 1'b0);
    check_val("e_mlen_rdy", bus.ready_i, 1'b1);
    bus.valid_i = 1'b1;
    bus.data_i = {32'hFFFF_FFFF, 32'(MAX_MLEN + 1)};
    @(negedge clk);
    bus.valid_i = 1'b0;
    check_val("e_mlen_error", in_error, 1'b1);
    check_val("e_mlen_ready", bus.ready_i, 1'b0);
    check_val("e_mlen_cv", bus.core_valid_o, 1'b0);

    // abort mid-frame by a new start while the old word is still offered
    run_frame("ab_old", 2'd2, 3'd2, 32'd100, 330, 1'b1, 50);
    run_frame("ab_new", 2'd0, 3'd3, 32'd0,   4,   1'b0, 0);

    // asynchronous reset mid-frame
    run_frame("rs_old", 2'd2, 3'd2, 32'd100, 330, 1'b0, 50);
    check_val("rs_pre_cv", bus.core_valid_o, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rs_mid");
    @(negedge clk);
    bus.valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rs_after");
    run_frame("kg5", 2'd0, 3'd5, 32'd0, 4, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
